// File: rtl/column_select_controller_if.sv
// Signal bundle between the Connect4 button/board side and column_select_controller.
// The board side drives buttons and drop_ack/drop_nack; the controller drives cursor, player and request.
interface column_select_controller_if;
  logic       btn_left;
  logic       btn_right;
  logic       btn_drop;
  logic       drop_ack;
  logic       drop_nack;
  logic [2:0] col;
  logic       player;
  logic       drop_req;
  logic       busy;

  modport master (
    output btn_left, btn_right, btn_drop, drop_ack, drop_nack,
    input  col, player, drop_req, busy
  );

  modport slave (
    input  btn_left, btn_right, btn_drop, drop_ack, drop_nack,
    output col, player, drop_req, busy
  );
endinterface

// File: rtl/column_select_controller.sv
// Connect4 button front end: synchronize, debounce and arbitrate buttons, keep the cursor column,
// auto-repeat held moves, and run the drop request/acknowledge handshake with the board logic.
module column_select_controller #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int REPEAT_CYCLES   = 50_000_000,
  parameter int NUM_COLS        = 7
) (
  input  logic                        clk,
  input  logic                        rst_n,
  column_select_controller_if.slave   bus,
  output logic [2:0]                  dbg_state
);

  localparam int MAX_CYCLES = (DEBOUNCE_CYCLES > REPEAT_CYCLES) ? DEBOUNCE_CYCLES : REPEAT_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES + 1);
  localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] REP_LAST  = CNT_W'(REPEAT_CYCLES - 1);
  localparam logic [2:0]       COL_LAST  = 3'(NUM_COLS - 1);
  localparam logic [2:0]       COL_RESET = 3'(NUM_COLS / 2);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DEBOUNCE = 3'd1,
    REPEAT   = 3'd2,
    REQ      = 3'd3,
    RELEASE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    SEL_LEFT  = 2'd0,
    SEL_RIGHT = 2'd1,
    SEL_DROP  = 2'd2
  } sel_t;

  state_t           state;
  sel_t             sel;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       col_q;
  logic             player_q;
  logic             drop_req_q;
  logic [1:0]       sync_left, sync_right, sync_drop;
  logic             s_left, s_right, s_drop, s_sel, s_any;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_left  <= '0;
      sync_right <= '0;
      sync_drop  <= '0;
    end else begin
      sync_left  <= {sync_left[0],  bus.btn_left};
      sync_right <= {sync_right[0], bus.btn_right};
      sync_drop  <= {sync_drop[0],  bus.btn_drop};
    end
  end

  assign s_left  = sync_left[1];
  assign s_right = sync_right[1];
  assign s_drop  = sync_drop[1];
  assign s_any   = s_left | s_right | s_drop;

  always_comb begin
    s_sel = 1'b0;
    case (sel)
      SEL_LEFT:  s_sel = s_left;
      SEL_RIGHT: s_sel = s_right;
      SEL_DROP:  s_sel = s_drop;
      default:   s_sel = 1'b0;
    endcase
  end

  function automatic logic [2:0] step_col(input logic [2:0] c, input sel_t s);
    if (s == SEL_LEFT) return (c == 3'd0) ? COL_LAST : c - 3'd1;
    return (c == COL_LAST) ? 3'd0 : c + 3'd1;
  endfunction

  // Drop handshake: drop_req rises when a drop is accepted and stays high, with col frozen,
  // until the edge that samples drop_ack or drop_nack; ack+nack together counts as a reject.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      sel        <= SEL_LEFT;
      cnt        <= '0;
      col_q      <= COL_RESET;
      player_q   <= 1'b0;
      drop_req_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (s_any) begin
            sel   <= s_drop ? SEL_DROP : (s_left ? SEL_LEFT : SEL_RIGHT);
            cnt   <= '0;
            state <= DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (!s_sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == DEB_LAST) begin
            cnt <= '0;
            if (sel == SEL_DROP) begin
              drop_req_q <= 1'b1;
              state      <= REQ;
            end else begin
              col_q <= step_col(col_q, sel);
              state <= REPEAT;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!s_sel) begin
            cnt   <= '0;
            state <= IDLE;
          end else if (cnt == REP_LAST) begin
            cnt   <= '0;
            col_q <= step_col(col_q, sel);
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REQ: begin
          if (bus.drop_ack || bus.drop_nack) begin
            drop_req_q <= 1'b0;
            if (bus.drop_ack && !bus.drop_nack) player_q <= ~player_q;
            cnt   <= '0;
            state <= RELEASE;
          end
        end
        RELEASE: begin
          // Wait for every button to be let go so a held drop cannot fire twice.
          if (!s_any) begin
            cnt   <= '0;
            state <= IDLE;
          end
        end
        default: begin
          cnt   <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.col      = col_q;
  assign bus.player   = player_q;
  assign bus.drop_req = drop_req_q;
  assign bus.busy     = (state != IDLE);
  assign dbg_state    = state;

endmodule

// File: tb/tb_column_select_controller.sv
// Bench for column_select_controller with short debounce/repeat periods, directed scenarios
// and randomized presses checked against a closed-form timing model.
module tb_column_select_controller;

  localparam int D = 4;
  localparam int R = 8;
  localparam int N = 7;

  logic       clk;
  logic       rst_n;
  logic [2:0] dbg_state;
  int         checks;
  int         errors;
  logic [2:0] exp_q[$];

  column_select_controller_if bus_if ();

  column_select_controller #(
    .DEBOUNCE_CYCLES(D),
    .REPEAT_CYCLES  (R),
    .NUM_COLS       (N)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus_if.slave),
    .dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic set_buttons(input bit l, input bit r, input bit d);
    bus_if.btn_left  = l;
    bus_if.btn_right = r;
    bus_if.btn_drop  = d;
  endtask

  task automatic apply_reset();
    set_buttons(0, 0, 0);
    bus_if.drop_ack  = 1'b0;
    bus_if.drop_nack = 1'b0;
    rst_n = 1'b0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  // driver: pulse the board response for one sampled edge
  task automatic respond(input bit ack, input bit nack);
    bus_if.drop_ack  = ack;
    bus_if.drop_nack = nack;
    tick(1);
    bus_if.drop_ack  = 1'b0;
    bus_if.drop_nack = 1'b0;
  endtask

  // reference model: moves produced by a clean press held for h sampled cycles
  function automatic int moves_for_hold(input int h);
    return (h >= D + 1) ? 1 + (h - D - 1) / R : 0;
  endfunction

  function automatic int model_col(input int c, input bit go_left, input int n);
    int v = c;
    for (int i = 0; i < n; i++) v = go_left ? (v + N - 1) % N : (v + 1) % N;
    return v;
  endfunction

  task automatic test_reset();
    apply_reset();
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL reset_col: got %0d expected 3", bus_if.col); end
    checks++; if (bus_if.player !== 1'b0) begin errors++; $display("FAIL reset_player: got %0b expected 0", bus_if.player); end
    checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL reset_drop_req: got %0b expected 0", bus_if.drop_req); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %0b expected 0", bus_if.busy); end
    checks++; if (dbg_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
  endtask

  task automatic test_right_hold();
    apply_reset();
    set_buttons(0, 1, 0);
    tick(6);
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL right_before_edge7: got %0d expected 3", bus_if.col); end
    tick(1);
    checks++; if (bus_if.col !== 3'd4) begin errors++; $display("FAIL right_first_move: got %0d expected 4", bus_if.col); end
    tick(7);
    checks++; if (bus_if.col !== 3'd4) begin errors++; $display("FAIL right_before_repeat: got %0d expected 4", bus_if.col); end
    tick(1);
    checks++; if (bus_if.col !== 3'd5) begin errors++; $display("FAIL right_repeat: got %0d expected 5", bus_if.col); end
    tick(5);
    set_buttons(0, 0, 0);
    tick(4);
    checks++; if (bus_if.col !== 3'd5) begin errors++; $display("FAIL right_after_release: got %0d expected 5", bus_if.col); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL right_idle: got %0b expected 0", bus_if.busy); end
  endtask

  task automatic test_bounce();
    apply_reset();
    set_buttons(0, 1, 0); tick(2);
    set_buttons(0, 0, 0); tick(1);
    set_buttons(0, 1, 0); tick(3);
    set_buttons(0, 0, 0); tick(6);
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL bounce_col: got %0d expected 3", bus_if.col); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL bounce_busy: got %0b expected 0", bus_if.busy); end
  endtask

  task automatic test_left_wrap();
    apply_reset();
    set_buttons(1, 0, 0); tick(D + 1 + 2 * R);
    set_buttons(0, 0, 0); tick(5);
    checks++; if (bus_if.col !== 3'd0) begin errors++; $display("FAIL left_to_zero: got %0d expected 0", bus_if.col); end
    set_buttons(1, 0, 0); tick(7);
    checks++; if (bus_if.col !== 3'd6) begin errors++; $display("FAIL left_wrap: got %0d expected 6", bus_if.col); end
    tick(8);
    checks++; if (bus_if.col !== 3'd5) begin errors++; $display("FAIL left_wrap_repeat: got %0d expected 5", bus_if.col); end
    set_buttons(0, 0, 0); tick(5);
  endtask

  task automatic test_drop_responses();
    bit seen;
    apply_reset();
    set_buttons(0, 0, 1); tick(6);
    checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL drop_early: got %0b expected 0", bus_if.drop_req); end
    tick(1);
    checks++; if (bus_if.drop_req !== 1'b1) begin errors++; $display("FAIL drop_req_rise: got %0b expected 1", bus_if.drop_req); end
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL drop_col: got %0d expected 3", bus_if.col); end
    respond(1, 0);
    checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL drop_req_fall: got %0b expected 0", bus_if.drop_req); end
    checks++; if (bus_if.player !== 1'b1) begin errors++; $display("FAIL ack_player: got %0b expected 1", bus_if.player); end
    seen = 0;
    for (int i = 0; i < 30; i++) begin tick(1); seen |= bus_if.drop_req; end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL held_drop_rerequest: got %0b expected 0", seen); end
    set_buttons(0, 0, 0); tick(4);
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL drop_release_idle: got %0b expected 0", bus_if.busy); end
    // response pulses outside a request are ignored
    respond(1, 0); tick(1);
    checks++; if (bus_if.player !== 1'b1) begin errors++; $display("FAIL stray_ack: got %0b expected 1", bus_if.player); end
    set_buttons(0, 0, 1); tick(D + 3); respond(0, 1); set_buttons(0, 0, 0); tick(5);
    checks++; if (bus_if.player !== 1'b1) begin errors++; $display("FAIL nack_player: got %0b expected 1", bus_if.player); end
    set_buttons(0, 0, 1); tick(D + 3); respond(1, 1); set_buttons(0, 0, 0); tick(5);
    checks++; if (bus_if.player !== 1'b1) begin errors++; $display("FAIL acknack_player: got %0b expected 1", bus_if.player); end
    set_buttons(0, 0, 1); tick(D + 3); respond(1, 0); set_buttons(0, 0, 0); tick(5);
    checks++; if (bus_if.player !== 1'b0) begin errors++; $display("FAIL second_ack_player: got %0b expected 0", bus_if.player); end
  endtask

  task automatic test_all_pressed();
    apply_reset();
    set_buttons(1, 1, 1); tick(D + 3);
    checks++; if (bus_if.drop_req !== 1'b1) begin errors++; $display("FAIL all_drop_req: got %0b expected 1", bus_if.drop_req); end
    tick(20);
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL all_col: got %0d expected 3", bus_if.col); end
    respond(1, 0); set_buttons(0, 0, 0); tick(5);
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL all_col_after: got %0d expected 3", bus_if.col); end
  endtask

  task automatic test_reset_during_req();
    apply_reset();
    set_buttons(0, 1, 0); tick(D + 3); set_buttons(0, 0, 0); tick(5);
    set_buttons(0, 0, 1); tick(D + 3); respond(1, 0); set_buttons(0, 0, 0); tick(5);
    set_buttons(0, 0, 1); tick(D + 3);
    checks++; if (bus_if.drop_req !== 1'b1) begin errors++; $display("FAIL pre_reset_req: got %0b expected 1", bus_if.drop_req); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL async_reset_req: got %0b expected 0", bus_if.drop_req); end
    set_buttons(0, 0, 0);
    tick(2);
    rst_n = 1'b1;
    tick(2);
    checks++; if (bus_if.col !== 3'd3) begin errors++; $display("FAIL post_reset_col: got %0d expected 3", bus_if.col); end
    checks++; if (bus_if.player !== 1'b0) begin errors++; $display("FAIL post_reset_player: got %0b expected 0", bus_if.player); end
    checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %0b expected 0", bus_if.busy); end
  endtask

  task automatic test_random();
    int ecol, eplay, h, wait_n, resp;
    bit l, r, d, seen, held;
    logic [2:0] m, exp_col;
    apply_reset();
    ecol = 3; eplay = 0;
    for (int it = 0; it < 30; it++) begin
      m = 3'($urandom_range(1, 7));
      {d, l, r} = m;
      if (d && $urandom_range(0, 3) == 0) begin
        h = $urandom_range(1, D);
        set_buttons(l, r, d);
        seen = 0;
        for (int i = 0; i < h; i++) begin tick(1); seen |= bus_if.drop_req; end
        set_buttons(0, 0, 0);
        for (int i = 0; i < 5; i++) begin tick(1); seen |= bus_if.drop_req; end
        checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rnd_short_drop it%0d: got %0b expected 0", it, seen); end
      end else if (d) begin
        set_buttons(l, r, d);
        tick(D + 2);
        checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL rnd_drop_early it%0d: got %0b expected 0", it, bus_if.drop_req); end
        tick(1);
        checks++; if (bus_if.drop_req !== 1'b1) begin errors++; $display("FAIL rnd_drop_req it%0d: got %0b expected 1", it, bus_if.drop_req); end
        wait_n = $urandom_range(0, 4);
        held = 1;
        for (int i = 0; i < wait_n; i++) begin tick(1); held &= bus_if.drop_req; end
        checks++; if (held !== 1'b1) begin errors++; $display("FAIL rnd_req_held it%0d: got %0b expected 1", it, held); end
        resp = $urandom_range(0, 2);
        respond(resp != 1, resp != 0);
        if (resp == 0) eplay = 1 - eplay;
        checks++; if (bus_if.drop_req !== 1'b0) begin errors++; $display("FAIL rnd_req_fall it%0d: got %0b expected 0", it, bus_if.drop_req); end
        checks++; if (bus_if.player !== 1'(eplay)) begin errors++; $display("FAIL rnd_player it%0d: got %0b expected %0d", it, bus_if.player, eplay); end
        set_buttons(0, 0, 0);
        tick(5);
      end else begin
        h = $urandom_range(1, 30);
        ecol = model_col(ecol, l, moves_for_hold(h));
        set_buttons(l, r, d);
        tick(h);
        set_buttons(0, 0, 0);
        tick(5);
      end
      exp_q.push_back(3'(ecol));
      exp_col = exp_q.pop_front();
      checks++; if (bus_if.col !== exp_col) begin errors++; $display("FAIL rnd_col it%0d: got %0d expected %0d", it, bus_if.col, exp_col); end
      checks++; if (bus_if.busy !== 1'b0) begin errors++; $display("FAIL rnd_idle it%0d: got %0b expected 0", it, bus_if.busy); end
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    set_buttons(0, 0, 0);
    bus_if.drop_ack  = 1'b0;
    bus_if.drop_nack = 1'b0;
    test_reset();
    test_right_hold();
    test_bounce();
    test_left_wrap();
    test_drop_responses();
    test_all_pressed();
    test_reset_during_req();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
